rgb_fpga_fb_arbiter: RTL and testbench
======================================

// Module: rgb_fpga_fb_arbiter
// PURPOSE
//  Shares one single-port, double-banked frame RAM between the line-fetch reader
//  (display path) and the host pixel writer. Reader reads the displayed bank; writer
//  writes the back bank. Banks swap only at a frame boundary (frame_rdy from display
//  control) after a host swap request, so the panel never shows a torn frame.
// PARAMETERS
//  ADDR_W     9   pixel-pair address width within one bank (16 rows x 32 cols)
//  DATA_W     24  RAM word width (upper+lower pixel, 4 bit/colour)
//  STARVE_MAX 8   max consecutive denied write cycles before forced write slot (guard only)
// PORTS
//  clk        in   1         system clock
//  rst_n      in   1         asynchronous reset, active low
//  enable     in   1         display running; 0 blocks reads
//  rd_req     in   1         reader requests one word
//  rd_addr    in   ADDR_W    reader address (displayed bank implied)
//  rd_gnt     out  1         read accepted this cycle (combinational)
//  rd_valid   out  1         rd_data valid; exactly 1 cycle after rd_gnt
//  rd_data    out  DATA_W    read data (= ram_rdata)
//  wr_req     in   1         writer requests one word write
//  wr_addr    in   ADDR_W    writer address (back bank implied)
//  wr_data    in   DATA_W    write data
//  wr_gnt     out  1         write performed this cycle (combinational)
//  swap_req   in   1         host pulse: back bank complete, display it
//  swap_ack   out  1         1-cycle pulse: swap done
//  frame_rdy  in   1         1-cycle pulse from display control: frame finished
//  disp_bank  out  1         currently displayed bank
//  ram_en     out  1         RAM access strobe
//  ram_we     out  1         RAM write enable
//  ram_addr   out  ADDR_W+1  {bank, addr}
//  ram_wdata  out  DATA_W    RAM write data
//  ram_rdata  in   DATA_W    RAM read data, 1-cycle synchronous latency
// BEHAVIOUR
//  Reset: state IDLE, disp_bank=0, swap_ack=0, rd_valid=0; other outputs follow grants (0).
//  Arbitration per cycle, at most one grant: rd_gnt = rd_req & enable & !force_wr;
//   wr_gnt = wr_req & !rd_gnt & (state != PENDING). ram_en = rd_gnt|wr_gnt, ram_we = wr_gnt.
//  ram_addr = rd_gnt ? {disp_bank, rd_addr} : {~disp_bank, wr_addr}; ram_wdata = wr_data.
//  rd_valid register = rd_gnt delayed 1 cycle; reset mid-read drops rd_valid.
//  FSM states:
//   IDLE    enable=0. Reads blocked, writes allowed. swap_req -> ACK (immediate swap).
//           enable=1 -> RUN.
//   RUN     swap_req -> PENDING. enable=0 -> IDLE.
//   PENDING swap latched; writes stalled (wr_gnt=0). frame_rdy -> ACK.
//           enable=0 -> ACK (no frame in flight, swap at once).
//   ACK     disp_bank toggles on entry; swap_ack=1 one cycle; -> RUN if enable else IDLE.
//  Simultaneous swap_req & frame_rdy in RUN: swap taken at that boundary (-> ACK directly).
//  swap_req in PENDING/ACK ignored (no queuing). frame_rdy without pending swap: no effect.
//  disp_bank changes only on ACK entry, so a read granted the same cycle uses the old bank.
// CONFIGURATION
//  FB_ARB_STARVE_GUARD_EN defined: counter (width clog2(STARVE_MAX+1)) counts cycles with
//   wr_req & !wr_gnt in RUN; at STARVE_MAX force_wr=1 for one cycle (write wins, rd_gnt=0),
//   counter clears on any wr_gnt or wr_req=0. Counter frozen in PENDING.
//  Undefined: force_wr tied 0; strict read priority, writer may starve indefinitely.
// STRUCTURE
//  rgb_fpga_pkg: FB_ADDR_W, FB_DATA_W constants, fb_arb_state_t enum {IDLE,RUN,PENDING,ACK}.
//  Sub-module rgb_fpga_fb_swap_fsm: FSM + disp_bank + swap_ack; arbitration mux stays top.
// TESTING
//  1 Reset, enable=1, rd_req=1 addr 0x005 -> rd_gnt=1, ram_addr=0x005, rd_valid next cycle.
//  2 rd_req & wr_req same cycle (guard off) -> rd_gnt=1, wr_gnt=0; wr_gnt when rd_req drops,
//    ram_addr=0x200|wr_addr, ram_we=1.
//  3 swap_req in RUN, writes pending -> wr_gnt=0 until frame_rdy; swap_ack 1 cycle later,
//    disp_bank 0->1, reads now ram_addr bit9=1.
//  4 swap_req & frame_rdy same cycle -> swap_ack next cycle, disp_bank toggles once.
//  5 enable=0 in PENDING -> swap_ack within 2 cycles, state IDLE, rd_gnt=0 with rd_req=1.
//  6 Guard on, STARVE_MAX=8, rd_req & wr_req held -> wr_gnt=1 on 9th cycle, rd_gnt=0 then.

Source files
------------

// File: rtl/rgb_fpga_pkg.sv
// rtl/rgb_fpga_pkg.sv - shared frame-buffer constants and arbiter state type
package rgb_fpga_pkg;

    localparam int FB_ADDR_W = 9;
    localparam int FB_DATA_W = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2,
        ACK     = 2'd3
    } fb_arb_state_t;

endpackage

// File: rtl/rgb_fpga_fb_swap_fsm.sv
// rtl/rgb_fpga_fb_swap_fsm.sv - bank-swap FSM: tracks displayed bank, swaps on frame boundary
module rgb_fpga_fb_swap_fsm
    import rgb_fpga_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          swap_req,
    input  logic          frame_rdy,
    output fb_arb_state_t state,
    output logic          disp_bank,
    output logic          swap_ack
);

    fb_arb_state_t state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            disp_bank <= 1'b0;
        end else begin
            state <= state_nxt;
            // Toggling on ACK entry keeps a read granted this cycle on the old bank
            if (state_nxt == ACK)
                disp_bank <= ~disp_bank;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (swap_req)
                    state_nxt = ACK;
                else if (enable)
                    state_nxt = RUN;
            end
            RUN: begin
                if (swap_req && (frame_rdy || !enable))
                    state_nxt = ACK;
                else if (swap_req)
                    state_nxt = PENDING;
                else if (!enable)
                    state_nxt = IDLE;
            end
            PENDING: begin
                if (frame_rdy || !enable)
                    state_nxt = ACK;
            end
            ACK: begin
                state_nxt = enable ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign swap_ack = (state == ACK);

endmodule

// File: rtl/rgb_fpga_fb_arbiter.sv
// rtl/rgb_fpga_fb_arbiter.sv - double-banked frame RAM arbiter (reader vs host writer)
// Optional write-starvation guard: FB_ARB_STARVE_GUARD_EN
module rgb_fpga_fb_arbiter
    import rgb_fpga_pkg::*;
#(
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = FB_DATA_W,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              swap_req,
    output logic              swap_ack,
    input  logic              frame_rdy,
    output logic              disp_bank,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W:0]   ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    fb_arb_state_t state;
    logic          force_wr;

    rgb_fpga_fb_swap_fsm u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .swap_req  (swap_req),
        .frame_rdy (frame_rdy),
        .state     (state),
        .disp_bank (disp_bank),
        .swap_ack  (swap_ack)
    );

    assign rd_gnt    = rd_req & enable & ~force_wr;
    assign wr_gnt    = wr_req & ~rd_gnt & (state != PENDING);
    assign ram_en    = rd_gnt | wr_gnt;
    assign ram_we    = wr_gnt;
    assign ram_addr  = rd_gnt ? {disp_bank, rd_addr} : {~disp_bank, wr_addr};
    assign ram_wdata = wr_data;
    assign rd_data   = ram_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_valid <= 1'b0;
        else
            rd_valid <= rd_gnt;
    end

`ifdef FB_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;

    // Only meaningful in RUN; in PENDING writes are stalled by design, not starved
    assign force_wr = (state == RUN) && (starve_cnt == CNT_W'(STARVE_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (state == PENDING)
            starve_cnt <= starve_cnt;
        else if (wr_gnt || !wr_req)
            starve_cnt <= '0;
        else if (state == RUN && starve_cnt != CNT_W'(STARVE_MAX))
            starve_cnt <= starve_cnt + CNT_W'(1);
    end
`else
    assign force_wr = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_fpga_fb_arbiter.sv
// tb/tb_rgb_fpga_fb_arbiter.sv - directed self-checking bench for rgb_fpga_fb_arbiter
module tb_rgb_fpga_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, rd_req, wr_req, swap_req, frame_rdy;
    logic [8:0]  rd_addr, wr_addr;
    logic [23:0] wr_data, rd_data, ram_wdata, ram_rdata;
    logic        rd_gnt, rd_valid, wr_gnt, swap_ack, disp_bank, ram_en, ram_we;
    logic [9:0]  ram_addr;

    int tests = 0;
    int fails = 0;
    int cnt;

    always #5 clk = ~clk;

    rgb_fpga_fb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .swap_req  (swap_req),
        .swap_ack  (swap_ack),
        .frame_rdy (frame_rdy),
        .disp_bank (disp_bank),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Synchronous RAM stand-in: read word is a known function of the address
    always @(posedge clk) begin
        if (ram_en && !ram_we)
            ram_rdata <= {14'h0, ram_addr} ^ 24'hA5A5A5;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 0; rd_req = 0; wr_req = 0; swap_req = 0; frame_rdy = 0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        #12;
        chk("rst_disp_bank", disp_bank, 0);
        chk("rst_swap_ack", swap_ack, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_ram_en", ram_en, 0);
        rst_n = 1'b1;
        step();

        // 1: single read
        enable = 1; rd_req = 1; rd_addr = 9'h005;
        #1;
        chk("t1_rd_gnt", rd_gnt, 1);
        chk("t1_ram_addr", ram_addr, 10'h005);
        chk("t1_ram_we", ram_we, 0);
        step();
        rd_req = 0;
        chk("t1_rd_valid", rd_valid, 1);
        chk("t1_rd_data", rd_data, 24'hA5A5A0);
        step();
        chk("t1_rd_valid_drop", rd_valid, 0);

        // 2: read beats write, write goes to the back bank
        rd_req = 1; rd_addr = 9'h010; wr_req = 1; wr_addr = 9'h033; wr_data = 24'h123456;
        #1;
        chk("t2_rd_gnt", rd_gnt, 1);
        chk("t2_wr_gnt_blocked", wr_gnt, 0);
        chk("t2_ram_addr_rd", ram_addr, 10'h010);
        step();
        rd_req = 0;
        #1;
        chk("t2_wr_gnt", wr_gnt, 1);
        chk("t2_ram_we", ram_we, 1);
        chk("t2_ram_addr_wr", ram_addr, 10'h233);
        chk("t2_ram_wdata", ram_wdata, 24'h123456);

`ifndef FB_ARB_STARVE_GUARD_EN
        // Strict read priority: writer never gets a slot while reads persist
        rd_req = 1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (wr_gnt) cnt++;
        end
        chk("nog_starve_wr_gnts", cnt, 0);
        rd_req = 0;
`endif
        step();

        // 3: swap in RUN stalls writes until frame boundary
        wr_req = 1; wr_addr = 9'h044; swap_req = 1;
        step();
        swap_req = 0;
        #1;
        chk("t3_pend_wr_gnt", wr_gnt, 0);
        chk("t3_pend_swap_ack", swap_ack, 0);
        chk("t3_pend_disp_bank", disp_bank, 0);
        step();
        chk("t3_pend_wr_gnt2", wr_gnt, 0);
        frame_rdy = 1;
        #1;
        chk("t3_ack_not_yet", swap_ack, 0);
        step();
        frame_rdy = 0;
        #1;
        chk("t3_swap_ack", swap_ack, 1);
        chk("t3_disp_bank", disp_bank, 1);
        chk("t3_wr_resumed", wr_gnt, 1);
        chk("t3_wr_addr_bank0", ram_addr, 10'h044);
        step();
        wr_req = 0; rd_req = 1; rd_addr = 9'h007;
        #1;
        chk("t3_swap_ack_pulse", swap_ack, 0);
        chk("t3_rd_bank1", ram_addr, 10'h207);
        step();
        rd_req = 0;

        // 4: swap_req and frame_rdy together
        swap_req = 1; frame_rdy = 1;
        step();
        swap_req = 0; frame_rdy = 0;
        #1;
        chk("t4_swap_ack", swap_ack, 1);
        chk("t4_disp_bank", disp_bank, 0);
        step();
        chk("t4_ack_drop", swap_ack, 0);
        chk("t4_bank_once", disp_bank, 0);

        // frame_rdy with nothing pending
        frame_rdy = 1;
        step();
        frame_rdy = 0;
        chk("fr_only_ack", swap_ack, 0);
        chk("fr_only_bank", disp_bank, 0);

        // 5: enable drops while PENDING
        swap_req = 1;
        step();
        swap_req = 0; enable = 0; rd_req = 1;
        #1;
        chk("t5_rd_blocked", rd_gnt, 0);
        step();
        chk("t5_swap_ack", swap_ack, 1);
        chk("t5_disp_bank", disp_bank, 1);
        step();
        wr_req = 1; wr_addr = 9'h001;
        #1;
        chk("t5_idle_ack_drop", swap_ack, 0);
        chk("t5_idle_rd_gnt", rd_gnt, 0);
        chk("t5_idle_wr_gnt", wr_gnt, 1);
        chk("t5_idle_wr_addr", ram_addr, 10'h001);
        wr_req = 0; rd_req = 0;

        // IDLE swap is immediate
        swap_req = 1;
        step();
        swap_req = 0;
        chk("idle_swap_ack", swap_ack, 1);
        chk("idle_swap_bank", disp_bank, 0);
        step();

`ifdef FB_ARB_STARVE_GUARD_EN
        // 6: forced write slot on the 9th contended cycle
        enable = 1;
        step();
        rd_req = 1; wr_req = 1; rd_addr = 9'h00A; wr_addr = 9'h0B0;
        cnt = 0;
        for (int i = 1; i < 9; i++) begin
            #1;
            if (wr_gnt || !rd_gnt) cnt++;
            step();
        end
        chk("t6_denied_8", cnt, 0);
        #1;
        chk("t6_force_wr_gnt", wr_gnt, 1);
        chk("t6_force_rd_gnt", rd_gnt, 0);
        step();
        chk("t6_rd_back", rd_gnt, 1);
        rd_req = 0; wr_req = 0;
        step();
`endif

        // Reset in the middle of a read
        enable = 1; rd_req = 1; rd_addr = 9'h003;
        #1;
        chk("rst_mid_rd_gnt", rd_gnt, 1);
        rst_n = 1'b0;
        step();
        chk("rst_mid_rd_valid", rd_valid, 0);
        chk("rst_mid_swap_ack", swap_ack, 0);
        rst_n = 1'b1; rd_req = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
